// File: rtl/mode_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mode_sequencer                                               |
// | Description : Key-driven operating-mode selector with ack handshake,      |
// |               ack timeout, key lock and idle auto-return from settings.   |
// | Revision    : 1.0 - initial release                                       |
// +----------------------------------------------------------------------------+

module mode_sequencer #(
    parameter int NUM_MODES    = 6,
    parameter int MODE_W       = 4,
    parameter int DEFAULT_MODE = 0,
    parameter int SETTING_MODE = 5,
    parameter int NEXT_KEY     = 12,
    parameter int PREV_KEY     = 13,
    parameter int LOCK_KEY     = 15,
    parameter int ACK_TIMEOUT  = 1024,
    parameter int IDLE_TIMEOUT = 50_000_000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [15:0]       key_pulse,
    input  logic              mode_ack,
    output logic [MODE_W-1:0] current_mode,
    output logic [MODE_W-1:0] pending_mode,
    output logic              mode_req,
    output logic              mode_change,
    output logic              locked,
    output logic              ack_timeout
);

    localparam int c_ACK_W  = (ACK_TIMEOUT  > 1) ? $clog2(ACK_TIMEOUT)  : 1;
    localparam int c_IDLE_W = (IDLE_TIMEOUT > 1) ? $clog2(IDLE_TIMEOUT) : 1;

    localparam logic [c_ACK_W-1:0]  c_ACK_LAST  = c_ACK_W'(ACK_TIMEOUT - 1);
    localparam logic [c_IDLE_W-1:0] c_IDLE_LAST = c_IDLE_W'(IDLE_TIMEOUT - 1);
    localparam logic [MODE_W-1:0]   c_DEFAULT   = MODE_W'(DEFAULT_MODE);
    localparam logic [MODE_W-1:0]   c_SETTING   = MODE_W'(SETTING_MODE);
    localparam logic [MODE_W-1:0]   c_LAST_MODE = MODE_W'(NUM_MODES - 1);
    localparam logic [3:0]          c_NEXT_IDX  = 4'(NEXT_KEY);
    localparam logic [3:0]          c_PREV_IDX  = 4'(PREV_KEY);
    localparam logic [3:0]          c_LOCK_IDX  = 4'(LOCK_KEY);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [MODE_W-1:0]   r_current;
    logic [MODE_W-1:0]   r_pending;
    logic [MODE_W-1:0]   r_prev;
    logic                r_mode_req;
    logic                r_mode_change;
    logic                r_locked;
    logic                r_ack_timeout;
    logic [c_ACK_W-1:0]  r_ack_cnt;
    logic [c_IDLE_W-1:0] r_idle_cnt;

    logic                w_key_onehot;
    logic [3:0]          w_key_idx;
    logic                w_lock_hit;
    logic                w_key_valid;
    logic [MODE_W-1:0]   w_key_target;
    logic                w_idle_cond;
    logic                w_idle_fire;
    logic                w_start;
    logic [MODE_W-1:0]   w_start_target;
    logic                w_commit;
    logic                w_forced;

    // A press is only meaningful when exactly one key bit is set.
    always_comb begin
        w_key_onehot = (key_pulse != 16'd0) && ((key_pulse & (key_pulse - 16'd1)) == 16'd0);
        w_key_idx    = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (key_pulse[i]) begin
                w_key_idx = 4'(i);
            end
        end
        w_lock_hit = w_key_onehot && (w_key_idx == c_LOCK_IDX);
    end

    always_comb begin
        w_key_valid  = 1'b0;
        w_key_target = r_current;
        if (w_key_onehot && !r_locked) begin
            if (int'(w_key_idx) < NUM_MODES) begin
                w_key_valid  = 1'b1;
                w_key_target = MODE_W'(w_key_idx);
            end else if (w_key_idx == c_NEXT_IDX) begin
                w_key_valid  = 1'b1;
                w_key_target = (r_current == c_LAST_MODE) ? '0 : r_current + MODE_W'(1);
            end else if (w_key_idx == c_PREV_IDX) begin
                w_key_valid  = 1'b1;
                w_key_target = (r_current == '0) ? c_LAST_MODE : r_current - MODE_W'(1);
            end
        end
    end

    // Any key activity both blocks and restarts the auto-return count.
    assign w_idle_cond = (r_state == ST_IDLE) && (r_current == c_SETTING) && (key_pulse == 16'd0);
    assign w_idle_fire = w_idle_cond && (r_idle_cnt == c_IDLE_LAST);

    always_comb begin
        w_state_nxt    = r_state;
        w_start        = 1'b0;
        w_start_target = r_current;
        w_commit       = 1'b0;
        w_forced       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_key_valid && (w_key_target != r_current)) begin
                    w_start        = 1'b1;
                    w_start_target = w_key_target;
                    w_state_nxt    = ST_REQ;
                end else if (w_idle_fire && (r_prev != r_current)) begin
                    w_start        = 1'b1;
                    w_start_target = r_prev;
                    w_state_nxt    = ST_REQ;
                end
            end
            ST_REQ: begin
                if (mode_ack) begin
                    w_commit    = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else if (r_ack_cnt == c_ACK_LAST) begin
                    w_commit    = 1'b1;
                    w_forced    = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_current     <= c_DEFAULT;
            r_pending     <= c_DEFAULT;
            r_prev        <= c_DEFAULT;
            r_mode_req    <= 1'b0;
            r_mode_change <= 1'b0;
            r_locked      <= 1'b0;
            r_ack_timeout <= 1'b0;
            r_ack_cnt     <= '0;
            r_idle_cnt    <= '0;
        end else begin
            r_mode_change <= w_commit;
            r_ack_timeout <= w_forced;

            if (w_start) begin
                r_mode_req <= 1'b1;
                r_pending  <= w_start_target;
            end
            if (w_commit) begin
                r_mode_req <= 1'b0;
                r_current  <= r_pending;
                r_prev     <= r_current;
            end

            if (w_lock_hit) begin
                r_locked <= ~r_locked;
            end

            if (w_start || w_commit) begin
                r_ack_cnt <= '0;
            end else if (r_state == ST_REQ) begin
                r_ack_cnt <= r_ack_cnt + c_ACK_W'(1);
            end

            if (!w_idle_cond || w_idle_fire) begin
                r_idle_cnt <= '0;
            end else begin
                r_idle_cnt <= r_idle_cnt + c_IDLE_W'(1);
            end
        end
    end

    assign current_mode = r_current;
    assign pending_mode = r_pending;
    assign mode_req     = r_mode_req;
    assign mode_change  = r_mode_change;
    assign locked       = r_locked;
    assign ack_timeout  = r_ack_timeout;

endmodule

`default_nettype wire

// File: tb/tb_mode_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_mode_sequencer                                            |
// | Description : Directed self-checking bench for mode_sequencer.            |
// | Revision    : 1.0 - initial release                                       |
// +----------------------------------------------------------------------------+

module tb_mode_sequencer;

    logic        clk;
    logic        rst_n;
    logic [15:0] key_pulse;
    logic        mode_ack;
    logic [3:0]  current_mode;
    logic [3:0]  pending_mode;
    logic        mode_req;
    logic        mode_change;
    logic        locked;
    logic        ack_timeout;

    int n_checks = 0;
    int n_errs   = 0;

    mode_sequencer #(
        .NUM_MODES    (6),
        .MODE_W       (4),
        .DEFAULT_MODE (0),
        .SETTING_MODE (5),
        .NEXT_KEY     (12),
        .PREV_KEY     (13),
        .LOCK_KEY     (15),
        .ACK_TIMEOUT  (8),
        .IDLE_TIMEOUT (16)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .key_pulse    (key_pulse),
        .mode_ack     (mode_ack),
        .current_mode (current_mode),
        .pending_mode (pending_mode),
        .mode_req     (mode_req),
        .mode_change  (mode_change),
        .locked       (locked),
        .ack_timeout  (ack_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errs++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic [15:0] k);
        key_pulse = k;
        tick();
        key_pulse = 16'd0;
    endtask

    task automatic commit_ack(input logic [3:0] exp_mode);
        mode_ack = 1'b1;
        tick();
        mode_ack = 1'b0;
        chk("commit_cur", current_mode, exp_mode);
        chk("commit_chg", mode_change, 1'b1);
        chk("commit_req", mode_req, 1'b0);
        chk("commit_ato", ack_timeout, 1'b0);
    endtask

    localparam logic [15:0] K_NEXT = 16'h1000;
    localparam logic [15:0] K_PREV = 16'h2000;
    localparam logic [15:0] K_LOCK = 16'h8000;

    initial begin
        rst_n     = 1'b0;
        key_pulse = 16'd0;
        mode_ack  = 1'b0;
        tick();
        tick();
        chk("rst_cur", current_mode, 4'd0);
        chk("rst_pend", pending_mode, 4'd0);
        chk("rst_req", mode_req, 1'b0);
        chk("rst_chg", mode_change, 1'b0);
        chk("rst_lock", locked, 1'b0);
        chk("rst_ato", ack_timeout, 1'b0);
        rst_n = 1'b1;
        tick();

        // Direct key 2 with ack three cycles after the request rises
        pulse(16'h0004);
        chk("k2_req1", mode_req, 1'b1);
        chk("k2_pend", pending_mode, 4'd2);
        tick();
        chk("k2_req2", mode_req, 1'b1);
        tick();
        chk("k2_req3", mode_req, 1'b1);
        chk("k2_nochg", mode_change, 1'b0);
        commit_ack(4'd2);
        tick();
        chk("k2_chg_one", mode_change, 1'b0);
        chk("k2_cur_hold", current_mode, 4'd2);

        // Stray ack, same-mode key, multi-bit and unused keys: no action
        mode_ack = 1'b1;
        tick();
        mode_ack = 1'b0;
        chk("stray_ack_chg", mode_change, 1'b0);
        chk("stray_ack_cur", current_mode, 4'd2);
        pulse(16'h0004);
        chk("same_mode_req", mode_req, 1'b0);
        pulse(16'h0006);
        chk("multi_bit_req", mode_req, 1'b0);
        pulse(16'h0100);
        chk("unused_key_req", mode_req, 1'b0);

        pulse(16'h0001);
        chk("k0_pend", pending_mode, 4'd0);
        commit_ack(4'd0);

        // PREV wraps 0 -> 5; keys ignored and lock toggles during REQ
        pulse(K_PREV);
        chk("prev_req", mode_req, 1'b1);
        chk("prev_pend", pending_mode, 4'd5);
        pulse(16'h0002);
        chk("inreq_pend", pending_mode, 4'd5);
        pulse(K_LOCK);
        chk("inreq_lock", locked, 1'b1);
        chk("inreq_lock_req", mode_req, 1'b1);
        pulse(K_LOCK);
        chk("inreq_unlock", locked, 1'b0);
        commit_ack(4'd5);

        // NEXT wraps 5 -> 0
        pulse(K_NEXT);
        chk("next_pend", pending_mode, 4'd0);
        chk("next_req", mode_req, 1'b1);
        commit_ack(4'd0);

        // Lock blocks direct and NEXT keys
        pulse(K_LOCK);
        chk("lock_on", locked, 1'b1);
        pulse(16'h0002);
        chk("locked_k1_req", mode_req, 1'b0);
        pulse(K_NEXT);
        chk("locked_next_req", mode_req, 1'b0);
        pulse(K_LOCK);
        chk("lock_off", locked, 1'b0);
        pulse(16'h0002);
        chk("unlock_k1_req", mode_req, 1'b1);
        chk("unlock_k1_pend", pending_mode, 4'd1);
        commit_ack(4'd1);

        // Ack timeout: commit on the 8th edge after mode_req rises
        pulse(16'h0008);
        chk("to_req", mode_req, 1'b1);
        for (int i = 1; i < 8; i++) begin
            tick();
            chk("to_wait_req", mode_req, 1'b1);
        end
        tick();
        chk("to_chg", mode_change, 1'b1);
        chk("to_ato", ack_timeout, 1'b1);
        chk("to_req_low", mode_req, 1'b0);
        chk("to_cur", current_mode, 4'd3);
        tick();
        chk("to_ato_one", ack_timeout, 1'b0);

        // Idle auto-return from setting mode 5 back to 3
        pulse(16'h0020);
        commit_ack(4'd5);
        for (int i = 1; i < 16; i++) begin
            tick();
            chk("idle_wait_req", mode_req, 1'b0);
        end
        tick();
        chk("idle_ret_req", mode_req, 1'b1);
        chk("idle_ret_pend", pending_mode, 4'd3);
        commit_ack(4'd3);

        // A key at idle cycle 10 restarts the count; return happens while locked
        pulse(16'h0020);
        commit_ack(4'd5);
        for (int i = 1; i < 10; i++) begin
            tick();
        end
        pulse(K_LOCK);
        chk("idle_lock", locked, 1'b1);
        chk("idle_lock_req", mode_req, 1'b0);
        for (int i = 1; i < 16; i++) begin
            tick();
            chk("idle_restart_req", mode_req, 1'b0);
        end
        tick();
        chk("idle_restart_ret", mode_req, 1'b1);
        chk("idle_restart_pend", pending_mode, 4'd3);

        // Asynchronous reset mid-request abandons it
        rst_n = 1'b0;
        #1;
        chk("mid_rst_req", mode_req, 1'b0);
        chk("mid_rst_cur", current_mode, 4'd0);
        chk("mid_rst_pend", pending_mode, 4'd0);
        chk("mid_rst_lock", locked, 1'b0);
        chk("mid_rst_chg", mode_change, 1'b0);
        tick();
        rst_n = 1'b1;
        mode_ack = 1'b1;
        tick();
        mode_ack = 1'b0;
        chk("post_rst_chg", mode_change, 1'b0);
        chk("post_rst_cur", current_mode, 4'd0);
        chk("post_rst_req", mode_req, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mode_sequencer.md
MODE_SEQUENCER -- requirements
Module: mode_sequencer

Interface
REQ-001 Parameter NUM_MODES, default 6, number of modes; legal range 2..16.
REQ-002 Parameter MODE_W, default 4, width of mode outputs; 2^MODE_W SHALL be >= NUM_MODES.
REQ-003 Parameter DEFAULT_MODE, default 0, mode after reset.
REQ-004 Parameter SETTING_MODE, default 5, mode subject to the idle auto-return.
REQ-005 Parameter NEXT_KEY / PREV_KEY / LOCK_KEY, defaults 12 / 13 / 15, key_pulse bit indices; distinct, each >= NUM_MODES.
REQ-006 Parameter ACK_TIMEOUT, default 1024, maximum cycles to wait for mode_ack.
REQ-007 Parameter IDLE_TIMEOUT, default 50_000_000, idle cycles in SETTING_MODE before auto-return.
REQ-008 clk  in  1  clock; all state on the rising edge.
REQ-009 rst_n  in  1  reset; asynchronous, active-low.
REQ-010 key_pulse  in  16  one-cycle key press pulses; bit i = key i.
REQ-011 mode_ack  in  1  downstream ready to switch; sampled only while mode_req = 1.
REQ-012 current_mode  out  MODE_W  committed active mode.
REQ-013 pending_mode  out  MODE_W  requested mode; valid while mode_req = 1.
REQ-014 mode_req  out  1  switch request, level, held until commit.
REQ-015 mode_change  out  1  one-cycle pulse on commit.
REQ-016 locked  out  1  mode keys disabled.
REQ-017 ack_timeout  out  1  one-cycle pulse when a commit was forced by timeout.

Function
REQ-018 FSM states SHALL be IDLE and REQ; reset state IDLE.
REQ-019 In IDLE, key_pulse SHALL be decoded only if exactly one bit is set; zero or multiple bits mean no action.
REQ-020 Direct key i < NUM_MODES SHALL target mode i; key bits in [NUM_MODES, 15] other than NEXT/PREV/LOCK SHALL be ignored.
REQ-021 NEXT SHALL target (current_mode+1) mod NUM_MODES; PREV SHALL target (current_mode-1) mod NUM_MODES, so 0 wraps to NUM_MODES-1.
REQ-022 LOCK SHALL toggle locked in any state and SHALL NOT affect an in-flight request.
REQ-023 While locked = 1, direct, NEXT and PREV keys SHALL be ignored.
REQ-024 A target equal to current_mode SHALL produce no request and no mode_change.
REQ-025 A valid target accepted in cycle N SHALL give mode_req = 1 and pending_mode = target from cycle N+1; FSM -> REQ.
REQ-026 In REQ, mode-select keys SHALL be ignored; pending_mode SHALL stay stable.
REQ-027 On mode_ack = 1 in REQ at cycle M, at M+1: current_mode = pending_mode, mode_change = 1, mode_req = 0, FSM -> IDLE.
REQ-028 An ack counter SHALL clear on entry to REQ; if it reaches ACK_TIMEOUT-1 without an ack, the commit of REQ-027 SHALL occur with ack_timeout = 1 in the same cycle as mode_change.
REQ-029 On every commit, prev_mode SHALL capture the old current_mode; prev_mode resets to DEFAULT_MODE.
REQ-030 Idle timer: counts while FSM = IDLE, current_mode = SETTING_MODE, and key_pulse = 0; clears on any nonzero key_pulse or when either other condition is false.
REQ-031 When the idle timer reaches IDLE_TIMEOUT-1, a request to prev_mode SHALL be issued per REQ-025, regardless of locked; the timer SHALL then clear.
REQ-032 Key activity in the cycle the idle timeout fires SHALL take priority: the key is decoded and the auto-return is cancelled.
REQ-033 mode_ack while mode_req = 0 SHALL be ignored.

Reset
REQ-034 Asserting rst_n low SHALL immediately set: current_mode = pending_mode = prev_mode = DEFAULT_MODE; mode_req = mode_change = locked = ack_timeout = 0; all counters 0; FSM = IDLE. This SHALL hold mid-request, and the request SHALL be abandoned.

Verification
REQ-035 Key bit 2 pulse, mode_ack high 3 cycles later -> mode_req = 1 and pending_mode = 2 for 3 cycles; then current_mode = 2 with a single mode_change pulse.
REQ-036 current_mode = 0, PREV pulse -> pending_mode = 5 (NUM_MODES = 6); after NEXT at mode 5 -> target 0.
REQ-037 LOCK pulse, then key bit 1 -> no mode_req; second LOCK, then key bit 1 -> request to 1.
REQ-038 Request with mode_ack tied 0, ACK_TIMEOUT = 8 -> commit 8 cycles after mode_req rises, with ack_timeout = mode_change = 1.
REQ-039 Mode 3 -> 5, IDLE_TIMEOUT = 16, no keys -> request to 3 after 16 idle cycles; a key pulse at cycle 10 restarts the count.
REQ-040 rst_n low while mode_req = 1 -> all outputs at reset values; a later ack causes no commit.
